// File: rtl/latch_bank_pkg.sv
// latch_bank_pkg: FSM states, counter width and range-checked one-hot decode for latch_bank_writer.
package latch_bank_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, PULSE = 2'd2, HOLD = 2'd3} state_t;
   localparam int CNT_W = 4;
   localparam int ONEHOT_W = 64;
   function automatic logic [ONEHOT_W-1:0] onehot_dec(input int idx, input int depth);
      return (idx >= 0 && idx < depth) ? ONEHOT_W'(1) << idx : '0;
   endfunction
endpackage

// File: rtl/pulse_timer.sv
// pulse_timer: loadable down-counter that stops at zero; times the latch enable pulse.
module pulse_timer
   import latch_bank_pkg::*;
(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Load,
   input  logic [CNT_W-1:0] Load_Val,
   output logic             Zero
);
   logic [CNT_W-1:0] cnt;
   assign Zero = cnt == '0;
   always_ff @(posedge Clk)
      if (Rst) cnt <= '0;
      else if (Load) cnt <= Load_Val;
      else if (!Zero) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/latch_bank_writer.sv
// latch_bank_writer: valid/ready write controller driving D/En of a Dlatch_NOR bank with setup/hold margins.
// Optional LATCH_BANK_WRITER_READBACK_EN adds Q_Bank readback compare with Mismatch/Err_Addr.
module latch_bank_writer
   import latch_bank_pkg::*;
#(
   parameter  int WIDTH        = 8,
   parameter  int DEPTH        = 4,
   parameter  int PULSE_CYCLES = 2,
   localparam int AW           = DEPTH > 1 ? $clog2(DEPTH) : 1
)(
   input  logic             Clk,
   input  logic             Rst,
   input  logic             In_Valid,
   output logic             In_Ready,
   input  logic [AW-1:0]    In_Addr,
   input  logic [WIDTH-1:0] In_Data,
   output logic [WIDTH-1:0] D,
   output logic [DEPTH-1:0] En,
   output logic             Busy,
   output logic             Addr_Err
`ifdef LATCH_BANK_WRITER_READBACK_EN
   ,
   input  logic [DEPTH*WIDTH-1:0] Q_Bank,
   output logic                   Mismatch,
   output logic [AW-1:0]          Err_Addr
`endif
);
   state_t state;
   logic [DEPTH-1:0] sel, dec;
   logic zero;
   assign dec = DEPTH'(onehot_dec(int'(In_Addr), DEPTH));
   pulse_timer u_timer (
      .Clk(Clk), .Rst(Rst), .Load(state == SETUP),
      .Load_Val(CNT_W'(PULSE_CYCLES - 1)), .Zero(zero)
   );
   // En and D are driven only from these flops so the latch enables never glitch
   always_ff @(posedge Clk)
      if (Rst) begin
         state    <= IDLE;
         In_Ready <= 1'b0;
         Busy     <= 1'b0;
         Addr_Err <= 1'b0;
         D        <= '0;
         En       <= '0;
         sel      <= '0;
      end else begin
         Addr_Err <= 1'b0;
         case (state)
            IDLE: begin
               In_Ready <= 1'b1;
               if (In_Valid && In_Ready) begin
                  state    <= SETUP;
                  In_Ready <= 1'b0;
                  Busy     <= 1'b1;
                  D        <= In_Data;
                  sel      <= dec;
                  Addr_Err <= ~|dec;
               end
            end
            SETUP: begin
               state <= PULSE;
               En    <= sel;
            end
            PULSE: if (zero) begin
               state <= HOLD;
               En    <= '0;
            end
            HOLD: begin
               state    <= IDLE;
               Busy     <= 1'b0;
               In_Ready <= 1'b1;
            end
         endcase
      end
`ifdef LATCH_BANK_WRITER_READBACK_EN
   logic [AW-1:0] addr;
   // an empty sel marks an out-of-range write, which is never compared
   always_ff @(posedge Clk)
      if (Rst) begin
         addr     <= '0;
         Mismatch <= 1'b0;
         Err_Addr <= '0;
      end else begin
         Mismatch <= 1'b0;
         if (state == IDLE && In_Valid && In_Ready) addr <= In_Addr;
         if (state == HOLD && |sel && Q_Bank[int'(addr)*WIDTH +: WIDTH] != D) begin
            Mismatch <= 1'b1;
            Err_Addr <= addr;
         end
      end
`endif
endmodule

// File: tb/tb_latch_bank_writer.sv
// tb_latch_bank_writer: three configurations (D4/P2, D5/P1, D4/P15) checked against a cycle-offset model.
module tb_latch_bank_writer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       r[3], v[3];
   logic [2:0] a[3];
   logic [7:0] dt[3];
   logic       qforce;

   logic       rdy0, rdy1, rdy2, bz0, bz1, bz2, ae0, ae1, ae2;
   logic [7:0] d0, d1, d2;
   logic [3:0] en0, en2;
   logic [4:0] en1;
   logic       rdy_a[3], bz_a[3], ae_a[3];
   logic [7:0] d_a[3];
   logic [4:0] en_a[3];
   assign rdy_a[0] = rdy0; assign rdy_a[1] = rdy1; assign rdy_a[2] = rdy2;
   assign bz_a[0]  = bz0;  assign bz_a[1]  = bz1;  assign bz_a[2]  = bz2;
   assign ae_a[0]  = ae0;  assign ae_a[1]  = ae1;  assign ae_a[2]  = ae2;
   assign d_a[0]   = d0;   assign d_a[1]   = d1;   assign d_a[2]   = d2;
   assign en_a[0]  = {1'b0, en0}; assign en_a[1] = en1; assign en_a[2] = {1'b0, en2};

   logic [7:0] lat[3][5];
`ifdef LATCH_BANK_WRITER_READBACK_EN
   logic [31:0] qb0, qb2;
   logic [39:0] qb1;
   logic        mm0, mm1, mm2;
   logic [1:0]  ea0, ea2;
   logic [2:0]  ea1;
   logic        mm_a[3];
   logic [2:0]  ea_a[3];
   assign mm_a[0] = mm0; assign mm_a[1] = mm1; assign mm_a[2] = mm2;
   assign ea_a[0] = {1'b0, ea0}; assign ea_a[1] = ea1; assign ea_a[2] = {1'b0, ea2};
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         qb0[k*8 +: 8] = lat[0][k];
         qb2[k*8 +: 8] = lat[2][k];
      end
      for (int k = 0; k < 5; k++) qb1[k*8 +: 8] = lat[1][k];
      if (qforce) qb0[15:8] = 8'h00;
   end
   function automatic logic [7:0] qword(int i, int ad);
      return i == 0 ? qb0[ad*8 +: 8] : i == 1 ? qb1[ad*8 +: 8] : qb2[ad*8 +: 8];
   endfunction
`endif

   latch_bank_writer #(.WIDTH(8), .DEPTH(4), .PULSE_CYCLES(2)) u0 (
      .Clk(clk), .Rst(r[0]), .In_Valid(v[0]), .In_Ready(rdy0), .In_Addr(a[0][1:0]),
      .In_Data(dt[0]), .D(d0), .En(en0), .Busy(bz0), .Addr_Err(ae0)
`ifdef LATCH_BANK_WRITER_READBACK_EN
      , .Q_Bank(qb0), .Mismatch(mm0), .Err_Addr(ea0)
`endif
   );
   latch_bank_writer #(.WIDTH(8), .DEPTH(5), .PULSE_CYCLES(1)) u1 (
      .Clk(clk), .Rst(r[1]), .In_Valid(v[1]), .In_Ready(rdy1), .In_Addr(a[1]),
      .In_Data(dt[1]), .D(d1), .En(en1), .Busy(bz1), .Addr_Err(ae1)
`ifdef LATCH_BANK_WRITER_READBACK_EN
      , .Q_Bank(qb1), .Mismatch(mm1), .Err_Addr(ea1)
`endif
   );
   latch_bank_writer #(.WIDTH(8), .DEPTH(4), .PULSE_CYCLES(15)) u2 (
      .Clk(clk), .Rst(r[2]), .In_Valid(v[2]), .In_Ready(rdy2), .In_Addr(a[2][1:0]),
      .In_Data(dt[2]), .D(d2), .En(en2), .Busy(bz2), .Addr_Err(ae2)
`ifdef LATCH_BANK_WRITER_READBACK_EN
      , .Q_Bank(qb2), .Mismatch(mm2), .Err_Addr(ea2)
`endif
   );

   int checks = 0, errors = 0;
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: each transaction is described only by its acceptance cycle, address and data
   int         dep[3] = '{4, 5, 4};
   int         pc[3]  = '{2, 1, 15};
   int         cyc = 0;
   bit         rst_prev[3] = '{1, 1, 1};
   bit         act[3] = '{0, 0, 0};
   int         tacc[3], maddr[3];
   logic [7:0] mdata[3], exp_d[3];
   int         mm_at[3] = '{-1, -1, -1};
   int         eax[3] = '{0, 0, 0};
   bit         started = 0;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         int o;
         bit bw;
         o  = cyc - tacc[i];
         bw = act[i] && o >= 1 && o <= 2 + pc[i];
`ifdef LATCH_BANK_WRITER_READBACK_EN
         if (r[i]) begin
            mm_at[i] = -1;
            eax[i]   = 0;
         end else if (act[i] && o == 2 + pc[i] && maddr[i] < dep[i] && qword(i, maddr[i]) != mdata[i]) begin
            mm_at[i] = cyc + 1;
            eax[i]   = maddr[i];
         end
`endif
         if (r[i]) begin
            act[i] = 0;
            exp_d[i] = 8'h00;
            rst_prev[i] = 1;
         end else begin
            if (!rst_prev[i] && !bw && v[i]) begin
               act[i] = 1;
               tacc[i] = cyc;
               maddr[i] = int'(a[i]);
               mdata[i] = dt[i];
               exp_d[i] = dt[i];
            end
            rst_prev[i] = 0;
         end
      end
      cyc++;
   end

   logic [4:0] en_prev[3];
   logic [7:0] d_prev[3];
   always @(negedge clk) if (started) begin
      for (int i = 0; i < 3; i++) begin
         int o;
         bit bw;
         o  = cyc - tacc[i];
         bw = act[i] && o >= 1 && o <= 2 + pc[i];
         chk($sformatf("ready[%0d]", i), 32'(rdy_a[i]), 32'(!rst_prev[i] && !bw));
         chk($sformatf("busy[%0d]", i), 32'(bz_a[i]), 32'(bw));
         chk($sformatf("d[%0d]", i), 32'(d_a[i]), 32'(exp_d[i]));
         chk($sformatf("en[%0d]", i), 32'(en_a[i]),
             (act[i] && o >= 2 && o <= 1 + pc[i] && maddr[i] < dep[i]) ? 32'(1) << maddr[i] : 32'd0);
         chk($sformatf("addr_err[%0d]", i), 32'(ae_a[i]), 32'(act[i] && o == 1 && maddr[i] >= dep[i]));
`ifdef LATCH_BANK_WRITER_READBACK_EN
         chk($sformatf("mismatch[%0d]", i), 32'(mm_a[i]), 32'(cyc == mm_at[i]));
         chk($sformatf("err_addr[%0d]", i), 32'(ea_a[i]), 32'(eax[i]));
`endif
         if (en_prev[i] != 0 && en_a[i] != 0) chk($sformatf("d_stable[%0d]", i), 32'(d_a[i]), 32'(d_prev[i]));
         for (int k = 0; k < dep[i]; k++) if (en_a[i][k]) lat[i][k] = d_a[i];
         en_prev[i] = en_a[i];
         d_prev[i]  = d_a[i];
      end
   end

   task automatic wait_ready(int i);
      int n;
      n = 0;
      while (rdy_a[i] !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout[%0d] got 0 expected 1", i);
      end
   endtask

   task automatic send(int i, logic [2:0] ad, logic [7:0] dd);
      wait_ready(i);
      v[i] = 1'b1; a[i] = ad; dt[i] = dd;
      @(negedge clk);
      v[i] = 1'b0;
   endtask

   task automatic en_width(int i, logic [2:0] ad, logic [7:0] dd, int p);
      int n;
      n = 0;
      send(i, ad, dd);
      repeat (p + 6) begin
         @(negedge clk);
         if (en_a[i] != 0) n++;
      end
      chk($sformatf("en_width[%0d]", i), n, p);
      chk($sformatf("width_word[%0d]", i), 32'(lat[i][ad]), 32'(dd));
   endtask

   initial begin
      logic [7:0] snap[5];
      qforce = 1'b0;
      for (int i = 0; i < 3; i++) begin
         r[i] = 1'b1; v[i] = 1'b0; a[i] = '0; dt[i] = '0;
         en_prev[i] = '0; d_prev[i] = '0;
         for (int k = 0; k < 5; k++) lat[i][k] = '0;
      end
      repeat (2) @(posedge clk);
      started = 1;
      @(negedge clk);
      chk("rst_ready", 32'(rdy0), 0);
      chk("rst_d", 32'(d0), 0);
      chk("rst_en", 32'(en0), 0);
      chk("rst_busy", 32'(bz0), 0);
      for (int i = 0; i < 3; i++) r[i] = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", 32'(rdy0), 1);
      // single write: addr 2, data A5
      send(0, 3'd2, 8'hA5);
      chk("w1_d_setup", 32'(d0), 32'hA5);
      chk("w1_en_setup", 32'(en0), 0);
      @(negedge clk); chk("w1_en_t2", 32'(en0), 32'b0100);
      @(negedge clk); chk("w1_en_t3", 32'(en0), 32'b0100);
      @(negedge clk); chk("w1_en_hold", 32'(en0), 0);
      @(negedge clk); chk("w1_ready_t5", 32'(rdy0), 1);
      chk("w1_word2", 32'(lat[0][2]), 32'hA5);
      // back-to-back with valid held high
      wait_ready(0);
      v[0] = 1'b1; a[0] = 3'd0; dt[0] = 8'h3C;
      @(negedge clk); a[0] = 3'd3; dt[0] = 8'hFF;
      repeat (3) @(negedge clk);
      chk("b2b_ready_t4", 32'(rdy0), 0);
      @(negedge clk); chk("b2b_ready_t5", 32'(rdy0), 1);
      @(negedge clk); v[0] = 1'b0;
      chk("b2b_d2", 32'(d0), 32'hFF);
      repeat (6) @(negedge clk);
      chk("b2b_word0", 32'(lat[0][0]), 32'h3C);
      chk("b2b_word3", 32'(lat[0][3]), 32'hFF);
      // reset during the first PULSE cycle
      send(0, 3'd1, 8'h5A);
      @(negedge clk);
      chk("mid_en_pulse", 32'(en0), 32'b0010);
      r[0] = 1'b1;
      @(negedge clk);
      chk("mid_en", 32'(en0), 0);
      chk("mid_busy", 32'(bz0), 0);
      chk("mid_d", 32'(d0), 0);
      r[0] = 1'b0;
      @(negedge clk); chk("mid_ready", 32'(rdy0), 1);
`ifdef LATCH_BANK_WRITER_READBACK_EN
      qforce = 1'b1;
      send(0, 3'd1, 8'h81);
      repeat (4) @(negedge clk);
      chk("rb_mismatch", 32'(mm0), 1);
      chk("rb_err_addr", 32'(ea0), 1);
      @(negedge clk); chk("rb_mismatch_once", 32'(mm0), 0);
      qforce = 1'b0;
      send(0, 3'd1, 8'h81);
      repeat (4) @(negedge clk);
      chk("rb_match", 32'(mm0), 0);
`endif
      // out-of-range address on the DEPTH=5 instance
      for (int k = 0; k < 5; k++) snap[k] = lat[1][k];
      send(1, 3'd5, 8'h77);
      chk("oor_addr_err", 32'(ae1), 1);
      @(negedge clk); chk("oor_addr_err_once", 32'(ae1), 0);
      repeat (3) @(negedge clk);
      for (int k = 0; k < 5; k++) chk($sformatf("oor_word%0d", k), 32'(lat[1][k]), 32'(snap[k]));
      en_width(1, 3'd4, 8'h11, 1);
      en_width(2, 3'd3, 8'hC3, 15);
      // randomized traffic on all three instances
      repeat (900) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            r[i]  = $urandom_range(0, 79) == 0;
            v[i]  = $urandom_range(0, 2) != 0;
            a[i]  = i == 1 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
            dt[i] = 8'($urandom);
         end
         qforce = $urandom_range(0, 3) == 0;
      end
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin r[i] = 1'b0; v[i] = 1'b0; end
      qforce = 1'b0;
      repeat (25) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/latch_bank_writer.md
# latch_bank_writer

Clocked write controller sitting directly upstream of a bank of `Dlatch_NOR` cells. It accepts address/data words over a valid/ready handshake and drives the shared `D` bus and one-hot `En` lines. Each word is written with guaranteed setup and hold margins: `D` is stable before `En` rises and stays stable after `En` falls. This lets asynchronous NOR latches be used safely as storage in a synchronous design.

## Interface
- `WIDTH`, 8: data bits per latch word (one `Dlatch_NOR` per bit).
- `DEPTH`, 4: number of latch words; `En` is one-hot over words.
- `PULSE_CYCLES`, 2: cycles `En` is held high. Legal range is 1..15.
- `Clk`  in  1  the single clock; all state updates on its rising edge.
- `Rst`  in  1  reset, synchronous, active-high.
- `In_Valid`  in  1  request valid.
- `In_Ready`  out  1  controller can accept a request.
- `In_Addr`  in  clog2(DEPTH)  target word index.
- `In_Data`  in  WIDTH  value to store.
- `D`  out  WIDTH  shared data bus to all latch `D` inputs.
- `En`  out  DEPTH  per-word latch enable, one-hot or zero.
- `Busy`  out  1  high from acceptance through HOLD.
- `Addr_Err`  out  1  one-cycle pulse when an out-of-range address is accepted.

## Operation
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - `In_Ready`=1.
  - On `In_Valid & In_Ready`, capture addr/data and go to SETUP.
- SETUP (1 cycle):
  - `D`=captured data.
  - `En`=0.
- PULSE (`PULSE_CYCLES` cycles):
  - `En[addr]`=1.
  - `D` is held.
  - A down-counter loaded with `PULSE_CYCLES-1` sets the exit; leave PULSE when the counter reaches 0.
- HOLD (1 cycle):
  - `En`=0.
  - `D` is held.
  - Then return to IDLE.
- `In_Valid` outside IDLE is ignored (`In_Ready`=0). There is no request queue.
- Out-of-range address (`In_Addr >= DEPTH`):
  - The request is accepted and the full SETUP/PULSE/HOLD sequence runs with `En`=0.
  - `Addr_Err` pulses in the SETUP cycle.
- `En` and `D` come straight from flops, with no combinational logic after the register. This keeps the level-sensitive latch enables glitch-free.
- `D` keeps its last driven value in IDLE.

## Timing
- Reset values:
  - `D`=0, `En`=0, `In_Ready`=0 while `Rst` is high, then `In_Ready`=1 in the first cycle after `Rst` falls.
  - `Busy`=0, `Addr_Err`=0, FSM=IDLE, counter=0.
- Handshake in cycle t:
  - SETUP is at t+1.
  - `En` is high for cycles t+2 .. t+1+P.
  - HOLD is at t+2+P.
  - `In_Ready`=1 again at t+3+P.
- Throughput: one word per 3+P cycles.
- Reset mid-operation: at the first edge with `Rst`=1, `En` goes to 0 and the FSM goes to IDLE. A partially written latch word is undefined, and the bench must not check it.
- Back-to-back requests: the second request is accepted in the first IDLE cycle. `D` changes only in that request's SETUP cycle, never while any `En` is high.

## Configuration
- Macro: `LATCH_BANK_WRITER_READBACK_EN`.
- Defined:
  - Adds input `Q_Bank` (DEPTH*WIDTH bits, word i at bits [i*WIDTH +: WIDTH]) from the latch `Q` outputs.
  - In HOLD, `Q_Bank[addr]` is compared with the captured data.
  - On a difference, output `Mismatch` pulses for 1 cycle in the cycle after HOLD, and `Err_Addr` (clog2(DEPTH)) registers the address.
  - Out-of-range writes are never compared.
  - Reset values: `Mismatch`=0, `Err_Addr`=0.
- Undefined: the readback ports, compare logic and flops are absent.

## Structure
- Package `latch_bank_pkg`:
  - FSM state enum (IDLE=2'd0, SETUP=2'd1, PULSE=2'd2, HOLD=2'd3).
  - Counter width constant (4 bits).
  - Helper function for one-hot decode with range check.
- Sub-module `pulse_timer`:
  - Loadable 4-bit down-counter with `Load`, `Load_Val` and `Zero` outputs.
  - Used for the PULSE duration.

## Test plan
- After reset, WIDTH=8, DEPTH=4, P=2, write addr 2 data 8'hA5:
  - `D`=A5 at t+1.
  - `En`=4'b0100 for exactly t+2..t+3.
  - `En`=0 at t+4.
  - `In_Ready`=1 at t+5.
  - Latch model word 2 = A5.
- Back-to-back writes (addr0=8'h3C, addr3=8'hFF) with `In_Valid` held high:
  - The second is accepted 5 cycles after the first.
  - `D` never changes while `En`≠0.
  - Both words hold their values.
- `In_Addr`=5 with DEPTH=5 (3-bit addr):
  - `Addr_Err` pulses once in SETUP.
  - `En` stays 0 for the whole sequence.
  - Latch contents are unchanged.
- Assert `Rst` for 1 cycle during the first PULSE cycle:
  - At the next edge `En`=0, `Busy`=0, `D`=0.
  - `In_Ready`=1 one cycle after `Rst` falls.
- P=1 and P=15: the `En` high width is exactly 1 and 15 cycles.
- With `LATCH_BANK_WRITER_READBACK_EN`, force `Q_Bank` word 1 to 8'h00 after writing 8'h81:
  - `Mismatch`=1 for one cycle after HOLD.
  - `Err_Addr`=1.
  - A matching write gives no pulse.
